// File: rtl/hicore_alu_sched_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | hicore_alu_sched_pkg : shared widths, slot ops and entry layout     |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package hicore_alu_sched_pkg;

  localparam int ROB_PTR_W    = 6;
  localparam int ALU_INFO_W   = 48;
  localparam int RS_DEPTH_DEF = 8;
  localparam int RS_NWK_DEF   = 2;

  typedef enum logic [1:0] {
    RS_HOLD  = 2'd0,
    RS_SHIFT = 2'd1,
    RS_LOAD  = 2'd2
  } rs_op_e;

  typedef struct packed {
    logic                  valid;
    logic [ROB_PTR_W-1:0]  rob_ptr;
    logic [ROB_PTR_W-1:0]  src1_tag;
    logic                  src1_rdy;
    logic [ROB_PTR_W-1:0]  src2_tag;
    logic                  src2_rdy;
    logic [ALU_INFO_W-1:0] payload;
  } alu_rs_entry_t;

  // Packed width of one entry for arbitrary tag/payload widths.
  function automatic int rs_entry_w(input int tag_w, input int payload_w);
    return 3 + 3 * tag_w + payload_w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hicore_alu_sched_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | hicore_alu_sched_if : dispatch and ALU issue handshakes             |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
interface hicore_alu_sched_if
  import hicore_alu_sched_pkg::*;
#(
  parameter int TAG_W     = ROB_PTR_W,
  parameter int PAYLOAD_W = ALU_INFO_W
) ();

  logic                 disp_valid;
  logic                 disp_ready;
  logic [TAG_W-1:0]     disp_rob_ptr;
  logic [TAG_W-1:0]     disp_src1_tag;
  logic                 disp_src1_rdy;
  logic [TAG_W-1:0]     disp_src2_tag;
  logic                 disp_src2_rdy;
  logic [PAYLOAD_W-1:0] disp_payload;

  logic                 issue_valid;
  logic                 issue_ready;
  logic [TAG_W-1:0]     issue_rob_ptr;
  logic [TAG_W-1:0]     issue_src1_tag;
  logic [TAG_W-1:0]     issue_src2_tag;
  logic [PAYLOAD_W-1:0] issue_payload;

  modport master (
    output disp_valid, disp_rob_ptr, disp_src1_tag, disp_src1_rdy,
           disp_src2_tag, disp_src2_rdy, disp_payload, issue_ready,
    input  disp_ready, issue_valid, issue_rob_ptr, issue_src1_tag,
           issue_src2_tag, issue_payload
  );

  modport slave (
    input  disp_valid, disp_rob_ptr, disp_src1_tag, disp_src1_rdy,
           disp_src2_tag, disp_src2_rdy, disp_payload, issue_ready,
    output disp_ready, issue_valid, issue_rob_ptr, issue_src1_tag,
           issue_src2_tag, issue_payload
  );

endinterface
`default_nettype wire

// File: rtl/hicore_alu_rs_entry.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | hicore_alu_rs_entry : one reservation slot with local wakeup        |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module hicore_alu_rs_entry
  import hicore_alu_sched_pkg::*;
#(
  parameter int  TAG_W     = ROB_PTR_W,
  parameter int  PAYLOAD_W = ALU_INFO_W,
  parameter int  NWK       = RS_NWK_DEF,
  localparam int ENTRY_W   = rs_entry_w(TAG_W, PAYLOAD_W)
) (
  input  wire logic                 clk,
  input  wire logic                 rst,
  input  wire logic                 flush,
  input  wire rs_op_e               op,
  input  wire logic [ENTRY_W-1:0]   shift_in,
  input  wire logic [ENTRY_W-1:0]   load_in,
  input  wire logic [NWK-1:0]       wk_valid,
  input  wire logic [NWK*TAG_W-1:0] wk_tag,
  output logic      [ENTRY_W-1:0]   entry_out
);

  typedef struct packed {
    logic                 valid;
    logic [TAG_W-1:0]     rob_ptr;
    logic [TAG_W-1:0]     src1_tag;
    logic                 src1_rdy;
    logic [TAG_W-1:0]     src2_tag;
    logic                 src2_rdy;
    logic [PAYLOAD_W-1:0] payload;
  } entry_t;

  entry_t base;
  entry_t entry_d;
  entry_t entry_q;

  // Wakeup is applied after the mux, so a loaded uop gets the dispatch
  // bypass and a shifted uop is woken in its new position.
  always_comb begin
    case (op)
      RS_LOAD:  base = load_in;
      RS_SHIFT: base = shift_in;
      default:  base = entry_q;
    endcase
    entry_d = base;
    for (int p = 0; p < NWK; p++) begin
      if (wk_valid[p]) begin
        if (wk_tag[p*TAG_W +: TAG_W] == base.src1_tag) entry_d.src1_rdy = 1'b1;
        if (wk_tag[p*TAG_W +: TAG_W] == base.src2_tag) entry_d.src2_rdy = 1'b1;
      end
    end
    if (flush) entry_d.valid = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) entry_q <= '0;
    else     entry_q <= entry_d;
  end

  assign entry_out = entry_q;

endmodule
`default_nettype wire

// File: rtl/hicore_alu_sched.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | hicore_alu_sched : collapsing-queue RS, oldest-ready ALU issue      |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module hicore_alu_sched
  import hicore_alu_sched_pkg::*;
#(
  parameter int  DEPTH     = RS_DEPTH_DEF,
  parameter int  TAG_W     = ROB_PTR_W,
  parameter int  PAYLOAD_W = ALU_INFO_W,
  parameter int  NWK       = RS_NWK_DEF,
  localparam int CNT_W     = $clog2(DEPTH + 1),
  localparam int IDX_W     = $clog2(DEPTH)
) (
  input  wire logic                 clk,
  input  wire logic                 rst,
  hicore_alu_sched_if.slave         bus,
  input  wire logic [NWK-1:0]       wk_valid,
  input  wire logic [NWK*TAG_W-1:0] wk_tag,
  input  wire logic                 flush,
  output logic      [CNT_W-1:0]     rs_count
);

  typedef struct packed {
    logic                 valid;
    logic [TAG_W-1:0]     rob_ptr;
    logic [TAG_W-1:0]     src1_tag;
    logic                 src1_rdy;
    logic [TAG_W-1:0]     src2_tag;
    logic                 src2_rdy;
    logic [PAYLOAD_W-1:0] payload;
  } entry_t;

  entry_t             slot      [DEPTH];
  entry_t             shift_src [DEPTH];
  rs_op_e             slot_op   [DEPTH];
  entry_t             disp_ent;
  logic [DEPTH-1:0]   elig;
  logic               any_elig;
  logic [IDX_W-1:0]   win_idx;
  logic               enq;
  logic               deq;
  logic [CNT_W-1:0]   enq_pos;
  logic [CNT_W-1:0]   count_d;
  logic [CNT_W-1:0]   count_q;

  always_comb begin
    disp_ent          = '0;
    disp_ent.valid    = 1'b1;
    disp_ent.rob_ptr  = bus.disp_rob_ptr;
    disp_ent.src1_tag = bus.disp_src1_tag;
    disp_ent.src1_rdy = bus.disp_src1_rdy;
    disp_ent.src2_tag = bus.disp_src2_tag;
    disp_ent.src2_rdy = bus.disp_src2_rdy;
    disp_ent.payload  = bus.disp_payload;
  end

  // Fixed priority: scanning downward leaves the lowest eligible index.
  always_comb begin
    win_idx  = '0;
    any_elig = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (elig[i]) begin
        win_idx  = IDX_W'(i);
        any_elig = 1'b1;
      end
    end
  end

  assign bus.issue_valid    = any_elig & ~flush;
  assign bus.issue_rob_ptr  = slot[win_idx].rob_ptr;
  assign bus.issue_src1_tag = slot[win_idx].src1_tag;
  assign bus.issue_src2_tag = slot[win_idx].src2_tag;
  assign bus.issue_payload  = slot[win_idx].payload;
  assign bus.disp_ready     = (count_q != CNT_W'(DEPTH));

  assign deq = bus.issue_valid & bus.issue_ready;
  assign enq = bus.disp_valid & bus.disp_ready & ~flush;

  // With a same-cycle issue the queue collapses first, so the new uop
  // lands one slot lower; that slot is always at or above the winner.
  always_comb begin
    enq_pos = deq ? (count_q - CNT_W'(1)) : count_q;
    count_d = flush ? '0 : (count_q + CNT_W'(enq) - CNT_W'(deq));
    for (int i = 0; i < DEPTH; i++) begin
      shift_src[i] = (i < DEPTH - 1) ? slot[(i + 1) % DEPTH] : '0;
      slot_op[i]   = RS_HOLD;
      if (enq && (CNT_W'(i) == enq_pos))      slot_op[i] = RS_LOAD;
      else if (deq && (IDX_W'(i) >= win_idx)) slot_op[i] = RS_SHIFT;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign rs_count = count_q;

  generate
    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
      assign elig[i] = slot[i].valid & slot[i].src1_rdy & slot[i].src2_rdy;

      hicore_alu_rs_entry #(
        .TAG_W     (TAG_W),
        .PAYLOAD_W (PAYLOAD_W),
        .NWK       (NWK)
      ) u_entry (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .op        (slot_op[i]),
        .shift_in  (shift_src[i]),
        .load_in   (disp_ent),
        .wk_valid  (wk_valid),
        .wk_tag    (wk_tag),
        .entry_out (slot[i])
      );
    end
  endgenerate

endmodule
`default_nettype wire

// File: doc/hicore_alu_sched.md
Name: hicore_alu_sched

Overview:
Collapsing-queue reservation station and issue scheduler for the single ALU pipe. It accepts decoded ALU µops from dispatch and holds them until both source operands are ready. Each entry tracks source readiness by snooping the writeback buses. Each cycle it issues the oldest ready entry into the ALU issue handshake. A commit-side flush discards all contents.

Parameters:
DEPTH, 8, number of RS entries (power of two not required, >=2)
TAG_W, 6, physical source tag width (ROB pointer width)
PAYLOAD_W, 48, opaque µop payload forwarded to ALU (msg, dir, op flags, info)
NWK, 2, number of wakeup (writeback) ports

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
disp_valid  in  1  dispatch µop valid
disp_ready  out  1  RS can accept a µop
disp_rob_ptr  in  TAG_W  destination ROB pointer
disp_src1_tag  in  TAG_W  source 1 producer tag
disp_src1_rdy  in  1  source 1 already available
disp_src2_tag  in  TAG_W  source 2 producer tag
disp_src2_rdy  in  1  source 2 already available
disp_payload  in  PAYLOAD_W  µop payload
wk_valid  in  NWK  wakeup port valid
wk_tag  in  NWK*TAG_W  wakeup tags, port i at [i*TAG_W +: TAG_W]
issue_valid  out  1  selected entry valid
issue_ready  in  1  ALU accepts
issue_rob_ptr  out  TAG_W  selected destination pointer
issue_src1_tag  out  TAG_W  selected source 1 tag (operand read)
issue_src2_tag  out  TAG_W  selected source 2 tag
issue_payload  out  PAYLOAD_W  selected payload
flush  in  1  commit flush
rs_count  out  $clog2(DEPTH+1)  occupied entries

Behaviour:
- Reset (async, rst=1): all entry valid bits 0, rs_count=0, issue_valid=0, disp_ready=1. Entry data fields are don't-care.
- Storage: entries 0..rs_count-1 are valid and contiguous. Index 0 is the oldest entry.
- disp_ready = (rs_count != DEPTH), computed from registered state only. It does not credit a same-cycle issue.
- Enqueue occurs when disp_valid & disp_ready & ~flush. The µop is written at index rs_count, or at rs_count-1 if an issue fires in the same cycle.
- Dispatch bypass: each srcN_rdy is written as disp_srcN_rdy | (any wk_valid[i] & wk_tag[i]==disp_srcN_tag).
- Wakeup: every valid entry sets srcN_rdy when any wk_valid[i] matches its srcN_tag. Multiple hits are OR-ed. The ready bit is sticky until the entry leaves.
- Eligibility: entry valid & src1_rdy & src2_rdy, using registered bits only. Wakeup-to-issue is therefore one cycle minimum; there is no same-cycle wakeup-to-issue.
- Select: the lowest eligible index wins (oldest-first). Fixed-priority encoder, combinational.
- issue_valid = any eligible & ~flush. The issue_* outputs are the winner's fields. Output fields are don't-care when issue_valid=0.
- Issue: on issue_valid & issue_ready the winner is removed at the clock edge. Entries above the winner shift down by one; entries below it hold. Wakeups that land in the same cycle are applied to entries in their shifted positions.
- Handshake: if issue_ready=0, the selection may change next cycle if an older entry becomes eligible. issue_valid never depends on issue_ready.
- Latency: a dispatched µop with both sources ready can assert issue_valid in the cycle after enqueue.
- Counter: rs_count += enq - deq, with enq and deq both possible in the same cycle.
- Flush: next edge clears all valid bits and sets rs_count=0. Dispatch in the flush cycle is dropped, and issue_valid=0 in the flush cycle.
- Full & issue same cycle: no enqueue that cycle (disp_ready=0); rs_count drops to DEPTH-1.
- DEPTH=1 is not supported.

Decomposition:
- Shared package holds:
  - width constants (TAG_W default tied to the ROB pointer width, PAYLOAD_W tied to the issue-to-ALU info width)
  - the entry struct fields {valid, rob_ptr, src1_tag, src1_rdy, src2_tag, src2_rdy, payload}.
- One sub-module, hicore_alu_rs_entry: a single slot with next-state mux (hold / shift-from-above / load-dispatch) and local wakeup compare.
- Top level holds the priority select, shift control, counter and output mux.

Test Plan (DEPTH=4, NWK=2):
1. Reset, then dispatch rob_ptr=5 with both rdy=1, issue_ready=1 -> issue_valid=1 next cycle with issue_rob_ptr=5; rs_count goes 1 then 0.
2. Dispatch A(src1 tag=9, rdy=0), then B(both ready); wk tag=9 in cycle 3 -> B issues first, A issues in cycle 4; age order is preserved after the collapse.
3. Fill 4 entries with unready tags -> disp_ready=0 and the 5th dispatch is ignored. Wake entry 2 with issue_ready=1 -> it issues, entries 3 shift to 2, rs_count=3, disp_ready=1.
4. Dispatch src1 tag=12 rdy=0 in the same cycle as wk_valid[1], wk_tag[1]=12 -> the entry is stored ready and issues next cycle (bypass).
5. Three eligible entries with issue_ready=0 for 3 cycles -> issue_valid stays 1 and the rob_ptr is stable (index 0); rs_count is unchanged.
6. Two entries present, flush asserted together with disp_valid and issue_ready -> no enqueue and no issue; rs_count=0 and issue_valid=0 next cycle.
